// File: rtl/sum_snapshot_streamer_if.sv
// Handshake bundle for sum_snapshot_streamer: chunk capture,
// snapshot request and the byte stream back to the host link.
interface sum_snapshot_streamer_if #(
   parameter int REGISTER_SIZE = 32,
   parameter int OUT_WIDTH     = 8,
   parameter int COUNT_WIDTH   = 16
);
   logic [REGISTER_SIZE-1:0] block_in;
   logic                     valid_in;
   logic                     request_in;
   logic                     ready_in;
   logic [OUT_WIDTH-1:0]     data_out;
   logic                     valid_out;
   logic                     busy_out;
   logic [COUNT_WIDTH-1:0]   count_out;

   modport master (
      output block_in, valid_in, request_in, ready_in,
      input  data_out, valid_out, busy_out, count_out
   );

   modport slave (
      input  block_in, valid_in, request_in, ready_in,
      output data_out, valid_out, busy_out, count_out
   );
endinterface

// File: rtl/sum_snapshot_streamer.sv
// Captures chunked running sums into a triple-buffered store and
// streams the latest complete sum out as little-endian words.
module sum_snapshot_streamer #(
   parameter int REGISTER_SIZE   = 32,
   parameter int NUM_BITS_STORED = 2048,
   parameter int OUT_WIDTH       = 8,
   parameter int COUNT_WIDTH     = 16
) (
   input logic clk_in,
   input logic rst_in,
   sum_snapshot_streamer_if.slave bus
);
   localparam int CHUNKS = NUM_BITS_STORED / REGISTER_SIZE;
   localparam int WPC    = REGISTER_SIZE / OUT_WIDTH;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int PW     = (WPC > 1) ? $clog2(WPC) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t state_q, state_n;

   logic [REGISTER_SIZE-1:0] mem [0:2][0:CHUNKS-1];

   logic [CW-1:0]            wr_idx, rd_idx, rd_addr;
   logic [PW-1:0]            sub;
   logic [1:0]               w_bank, l_bank, s_bank;
   logic [1:0]               w_n, l_n, s_n, tmp;
   logic                     has_sum, l_valid, l_valid_n;
   logic [REGISTER_SIZE-1:0] sh, sh_next, rd_word;
   logic [OUT_WIDTH-1:0]     dout;
   logic [COUNT_WIDTH-1:0]   count;
   logic                     complete, accept, xfer, last, rel;

   assign complete = bus.valid_in && (wr_idx == CW'(CHUNKS-1));
   assign last     = (rd_idx == CW'(CHUNKS-1)) && (sub == PW'(WPC-1));
   assign rd_addr  = (state_q == LOAD) ? '0 : rd_idx + CW'(1);
   assign rd_word  = mem[s_bank][rd_addr];
   assign sh_next  = sh >> OUT_WIDTH;

   assign bus.data_out  = dout;
   assign bus.valid_out = (state_q == SEND);
   assign bus.busy_out  = (state_q != IDLE);
   assign bus.count_out = count;

   always_comb begin
      state_n = state_q;
      accept  = 1'b0;
      xfer    = 1'b0;
      rel     = 1'b0;
      unique case (state_q)
         IDLE: if (bus.request_in && has_sum) begin
            accept  = 1'b1;
            state_n = LOAD;
         end
         LOAD: state_n = SEND;
         SEND: if (bus.ready_in) begin
            xfer = 1'b1;
            if (last) begin
               rel     = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Bank roles are a permutation of 0..2, so the third is 3-a-b.
   always_comb begin
      w_n       = w_bank;
      l_n       = l_bank;
      s_n       = s_bank;
      tmp       = l_bank;
      l_valid_n = l_valid;
      if (accept) begin
         s_n       = l_bank;
         l_n       = s_bank;
         l_valid_n = 1'b0;
      end
      if (complete) begin
         tmp       = w_bank;
         w_n       = 2'd3 - tmp - s_n;
         l_n       = tmp;
         l_valid_n = 1'b1;
      end else if (rel && !l_valid) begin
         // Nothing newer arrived: the streamed bank is still latest.
         l_n       = s_bank;
         s_n       = l_bank;
         l_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && bus.valid_in) mem[w_bank][wr_idx] <= bus.block_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         sub     <= '0;
         w_bank  <= 2'd0;
         l_bank  <= 2'd1;
         s_bank  <= 2'd2;
         has_sum <= 1'b0;
         l_valid <= 1'b0;
         count   <= '0;
         sh      <= '0;
         dout    <= '0;
      end else begin
         w_bank  <= w_n;
         l_bank  <= l_n;
         s_bank  <= s_n;
         l_valid <= l_valid_n;
         if (bus.valid_in)
            wr_idx <= complete ? '0 : wr_idx + CW'(1);
         if (complete) begin
            has_sum <= 1'b1;
            count   <= count + COUNT_WIDTH'(1);
         end
         if (state_q == LOAD) begin
            rd_idx <= '0;
            sub    <= '0;
            sh     <= rd_word;
            dout   <= rd_word[OUT_WIDTH-1:0];
         end else if (xfer && !last) begin
            if (sub == PW'(WPC-1)) begin
               rd_idx <= rd_addr;
               sub    <= '0;
               sh     <= rd_word;
               dout   <= rd_word[OUT_WIDTH-1:0];
            end else begin
               sub  <= sub + PW'(1);
               sh   <= sh_next;
               dout <= sh_next[OUT_WIDTH-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_sum_snapshot_streamer.sv
// Directed bench for sum_snapshot_streamer: capture, stream,
// backpressure, overlap, partial/simultaneous and reset cases.
module tb_sum_snapshot_streamer;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sum_snapshot_streamer_if bus ();

   sum_snapshot_streamer dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input bit inc,
                                           input logic [7:0] c,
                                           input int i);
      if (!inc) return c;
      return (i % 4 == 0) ? 8'(i / 4) : 8'h00;
   endfunction

   task automatic feed(input bit inc, input logic [7:0] c,
                       input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         bus.valid_in = 1'b1;
         bus.block_in = inc ? 32'(k) : {4{c}};
         tick();
      end
      bus.valid_in = 1'b0;
   endtask

   task automatic req_start();
      bus.request_in = 1'b1;
      tick();
      bus.request_in = 1'b0;
      chk("busy_after_req", 32'(bus.busy_out), 32'd1);
      chk("valid_t1", 32'(bus.valid_out), 32'd0);
      tick();
      chk("valid_t2", 32'(bus.valid_out), 32'd1);
   endtask

   task automatic req_ignored();
      bus.request_in = 1'b1;
      tick();
      bus.request_in = 1'b0;
      chk("req_ignored", 32'(bus.busy_out), 32'd0);
      tick();
      chk("req_ignored_v", 32'(bus.valid_out), 32'd0);
   endtask

   // Collect words; optionally feed sums BB then CC concurrently.
   task automatic stream_body(input bit inc, input logic [7:0] c,
                              input bit bp, input int nfeed,
                              input int abort_after);
      int   words  = 0;
      int   cycles = 0;
      int   fed    = 0;
      bit   stall  = 0;
      logic [7:0] prev = '0;
      while (words < 256 && cycles < 2000 &&
             !(abort_after > 0 && words == abort_after)) begin
         bus.ready_in = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (fed < nfeed) begin
            bus.valid_in = 1'b1;
            bus.block_in = (fed < 64) ? 32'hBBBBBBBB : 32'hCCCCCCCC;
            fed++;
         end else begin
            bus.valid_in = 1'b0;
         end
         if (stall) begin
            chk("stall_valid", 32'(bus.valid_out), 32'd1);
            chk("stall_data", 32'(bus.data_out), 32'(prev));
         end
         stall = 0;
         if (bus.valid_out) begin
            if (bus.ready_in) begin
               chk($sformatf("word%0d", words), 32'(bus.data_out),
                   32'(exp_byte(inc, c, words)));
               words++;
            end else begin
               stall = 1;
               prev  = bus.data_out;
            end
         end
         tick();
         cycles++;
      end
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b1;
      if (abort_after == 0) begin
         chk("word_count", 32'(words), 32'd256);
         chk("end_valid", 32'(bus.valid_out), 32'd0);
         chk("end_busy", 32'(bus.busy_out), 32'd0);
         if (!bp) chk("throughput", 32'(cycles), 32'd256);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.block_in   = '0;
      bus.valid_in   = 1'b0;
      bus.request_in = 1'b0;
      bus.ready_in   = 1'b1;
      tick();
      tick();
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_busy", 32'(bus.busy_out), 32'd0);
      chk("rst_count", 32'(bus.count_out), 32'd0);
      rst = 1'b0;
      req_ignored();

      feed(1'b1, 8'h00, 0, 64);
      chk("single_count", 32'(bus.count_out), 32'd1);
      req_start();
      stream_body(1'b1, 8'h00, 1'b0, 0, 0);
      chk("single_count2", 32'(bus.count_out), 32'd1);

      req_start();
      stream_body(1'b1, 8'h00, 1'b1, 0, 0);

      do_reset();
      feed(1'b0, 8'hAA, 0, 64);
      chk("ovl_count_a", 32'(bus.count_out), 32'd1);
      req_start();
      stream_body(1'b0, 8'hAA, 1'b0, 128, 0);
      chk("ovl_count", 32'(bus.count_out), 32'd3);
      req_start();
      stream_body(1'b0, 8'hCC, 1'b0, 0, 0);

      do_reset();
      feed(1'b0, 8'hAA, 0, 64);
      feed(1'b0, 8'hBB, 0, 10);
      req_start();
      stream_body(1'b0, 8'hAA, 1'b0, 0, 0);
      feed(1'b0, 8'hBB, 10, 53);
      bus.valid_in   = 1'b1;
      bus.block_in   = 32'hBBBBBBBB;
      bus.request_in = 1'b1;
      tick();
      bus.valid_in   = 1'b0;
      bus.request_in = 1'b0;
      chk("simul_count", 32'(bus.count_out), 32'd2);
      chk("simul_busy", 32'(bus.busy_out), 32'd1);
      tick();
      chk("simul_valid", 32'(bus.valid_out), 32'd1);
      stream_body(1'b0, 8'hAA, 1'b0, 0, 0);
      req_start();
      stream_body(1'b0, 8'hBB, 1'b0, 0, 0);

      req_start();
      stream_body(1'b0, 8'hBB, 1'b0, 0, 100);
      chk("mid_valid_pre", 32'(bus.valid_out), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", 32'(bus.valid_out), 32'd0);
      chk("mid_busy", 32'(bus.busy_out), 32'd0);
      chk("mid_count", 32'(bus.count_out), 32'd0);
      chk("mid_data", 32'(bus.data_out), 32'd0);
      req_ignored();
      feed(1'b1, 8'h00, 0, 10);
      req_ignored();
      feed(1'b1, 8'h00, 10, 54);
      chk("post_count", 32'(bus.count_out), 32'd1);
      req_start();
      stream_body(1'b1, 8'h00, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
